// File: rtl/csa_accumulator.sv
// Purpose: frame accumulator built on a 3:2 carry-save step per operand,
//          with one carry-propagate addition at end of frame.
// Latency: result valid two cycles after the edge that accepts the last operand.
// Backpressure: in_ready low while resolving/presenting; result held until out_ready.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake; in_data unsigned N-bit, in_last ends frame
//   out_valid/out_ready result handshake; out_sum = frame sum mod 2^W,
//                      out_err = frame held more than M operands
module csa_accumulator #(
  parameter int N = 4,
  parameter int M = 8,
  localparam int W = N + $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_err
);

  localparam int CW = $clog2(M + 1);
  // The carry-propagate add is split into a low and a high half so the
  // long carry chain is cut by a register; the high half adds the low carry.
  localparam int LO = W / 2;
  localparam int HI = W - LO;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cy_q, cy_d;
  logic           ph_q, ph_d;

  logic           accept;
  logic [W-1:0]   x;
  logic [LO:0]    lo_add;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_err   = err_q;

  assign accept = in_valid && in_ready;
  assign x      = W'(in_data);
  assign lo_add = (LO + 1)'(s_q[LO-1:0]) + (LO + 1)'(c_q[LO-1:0]);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    ph_d    = ph_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          // Carry-save step: sum bits and majority carries, no propagation.
          s_d = s_q ^ c_q ^ x;
          c_d = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
          // Counter saturates at M; an accept beyond that flags the frame.
          if (cnt_q == CW'(M)) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          ph_d    = 1'b0;
          state_d = in_last ? RESOLVE : ACCUM;
        end
      end

      RESOLVE: begin
        if (!ph_q) begin
          sum_d[LO-1:0] = lo_add[LO-1:0];
          cy_d          = lo_add[LO];
          ph_d          = 1'b1;
        end else begin
          sum_d[W-1:LO] = s_q[W-1:LO] + c_q[W-1:LO] + HI'(cy_q);
          ph_d          = 1'b0;
          state_d       = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      ph_q    <= ph_d;
    end
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits.
REQ-002 SHALL have parameter M, default 8, maximum operands per frame without overflow.
REQ-003 SHALL derive local parameter W = N + $clog2(M), default 7, the result width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operand present on in_data.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port in_data  input  N  unsigned operand.
REQ-009 SHALL have port in_last  input  1  marks the final operand of a frame; valid only with in_valid.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_sum  output  W  resolved frame sum, modulo 2^W.
REQ-013 SHALL have port out_err  output  1  frame contained more than M operands.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, RESOLVE, DONE.
REQ-015 SHALL hold W-bit redundant registers S (sum vector) and C (carry vector), an operand counter, and an err flag.
REQ-016 SHALL accept an operand on a cycle where in_valid && in_ready, i.e. handshake only.
REQ-017 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in RESOLVE and DONE.
REQ-018 SHALL, on each accept, perform a 3:2 carry-save step with X = zero-extended in_data:
  - S <= S ^ C ^ X
  - C <= (majority(S, C, X)) << 1
  - truncate to W bits
  - no carry propagation in this step.
REQ-019 SHALL apply these transitions:
  - IDLE -> ACCUM on accept without in_last
  - IDLE or ACCUM -> RESOLVE on accept with in_last
  - ACCUM holds otherwise.
REQ-020 SHALL perform a single carry-propagate addition in RESOLVE: out_sum <= (S + C) mod 2^W, then transition to DONE.
REQ-021 SHALL meet this latency: last operand accepted at edge t -> out_valid = 1 after edge t+2.
REQ-022 SHALL keep out_valid = 1 only in DONE, with out_sum and out_err held stable until out_valid && out_ready.
REQ-023 SHALL, on the DONE handshake:
  - transition to IDLE
  - clear S, C, counter and err in the same edge
  - drop out_valid on the following cycle.
REQ-024 SHALL keep the operand counter saturating, and set err when an accept occurs with the counter already at M; err stays set for the rest of the frame.
REQ-025 SHALL continue accumulating operands beyond M modulo 2^W; only the sum wraps, never the FSM.
REQ-026 SHALL treat a single-operand frame (in_last on the first accept) as valid: IDLE -> RESOLVE directly.
REQ-027 SHALL ignore in_data, in_last and in_valid whenever in_ready = 0, with no state change.
REQ-028 SHALL ignore out_ready outside DONE.

Reset
REQ-029 SHALL, when rst is asserted at any time including mid-frame, RESOLVE or DONE, immediately:
  - enter IDLE
  - clear S, C, counter, err and out_sum to 0
  - drive out_valid = 0 and in_ready = 1 (combinationally from state).
REQ-030 SHALL discard a partially accumulated frame on reset; the first accept after rst deasserts starts a new frame.

Verification
REQ-031 SHALL pass: N=4, M=8, operands 5, 9, 15 (last on 15), out_ready = 1 -> out_sum = 29, out_err = 0, out_valid exactly 2 cycles after the last accept, for one cycle.
REQ-032 SHALL pass: eight operands of 15, last on the eighth -> out_sum = 120, out_err = 0.
REQ-033 SHALL pass: nine operands of 15 -> out_sum = 7 (135 mod 128), out_err = 1.
REQ-034 SHALL pass: single operand 0 with in_last -> out_sum = 0, out_err = 0, state path IDLE -> RESOLVE -> DONE.
REQ-035 SHALL pass: frame 3, 4 (sum 7), out_ready held 0 for 5 cycles in DONE -> out_valid and out_sum = 7 stable, in_ready = 0 throughout, and an in_valid pulse during this window is ignored (next frame 1 alone -> 1).
REQ-036 SHALL pass: rst pulsed after operands 10, 10 without last, then frame 2, 3 -> out_sum = 5, out_err = 0, with no residue from the aborted frame.
